// File: rtl/wb_register_file_if.sv
// rtl/wb_register_file_if.sv - MEM/WB write-back and register read bus
interface wb_register_file_if;
  logic        i_reg_write;
  logic [1:0]  i_mem_to_reg;
  logic [4:0]  i_write_register;
  logic [31:0] i_result;
  logic [31:0] i_mem_read_data;
  logic [31:0] i_pc_4;
  logic [31:0] i_imm_ext_out;
  logic [4:0]  i_rs_addr;
  logic [4:0]  i_rt_addr;
  logic [4:0]  i_debug_addr;
  logic [31:0] o_rs_data;
  logic [31:0] o_rt_data;
  logic [31:0] o_debug_data;
  logic [31:0] o_wb_data;
  logic        o_wb_en;
  logic [31:0] o_wb_count;

  modport slave (
    input  i_reg_write, i_mem_to_reg, i_write_register, i_result,
           i_mem_read_data, i_pc_4, i_imm_ext_out,
           i_rs_addr, i_rt_addr, i_debug_addr,
    output o_rs_data, o_rt_data, o_debug_data, o_wb_data, o_wb_en, o_wb_count
  );

  modport master (
    output i_reg_write, i_mem_to_reg, i_write_register, i_result,
           i_mem_read_data, i_pc_4, i_imm_ext_out,
           i_rs_addr, i_rt_addr, i_debug_addr,
    input  o_rs_data, o_rt_data, o_debug_data, o_wb_data, o_wb_en, o_wb_count
  );
endinterface

// File: rtl/wb_register_file.sv
// rtl/wb_register_file.sv - write-back mux, 32x32 register file with bypass, retired-write counter
module wb_register_file #(
  parameter logic [31:0] SP_RESET = 32'h0000_07fc,
  parameter logic [31:0] GP_RESET = 32'h0000_1800
) (
  input logic               clk,
  input logic               reset,
  wb_register_file_if.slave bus
);

  logic [31:0] regs [32];
  logic [31:0] wb_data;
  logic        wb_en;
  logic [31:0] wb_count_q;
  logic [31:0] rs_data;
  logic [31:0] rt_data;
  logic [31:0] debug_data;

  // Select the write-back value from the MEM/WB sources
  always_comb begin
    wb_data = bus.i_result;
    unique case (bus.i_mem_to_reg)
      2'b00: wb_data = bus.i_result;
      2'b01: wb_data = bus.i_mem_read_data;
      2'b10: wb_data = bus.i_pc_4;
      2'b11: wb_data = bus.i_imm_ext_out;
      default: wb_data = bus.i_result;
    endcase
  end

  // A write only counts when enabled, not aimed at $zero, and out of reset
  assign wb_en = bus.i_reg_write & (bus.i_write_register != 5'd0) & reset;

  // Register storage; reset loads $gp/$sp defaults, everything else clears
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < 32; i++) begin
        if (i == 28)      regs[i] <= GP_RESET;
        else if (i == 29) regs[i] <= SP_RESET;
        else              regs[i] <= 32'd0;
      end
    end else if (wb_en) begin
      regs[bus.i_write_register] <= wb_data;
    end
  end

  // Count retired effective writes, wrapping silently
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) wb_count_q <= 32'd0;
    else if (wb_en) wb_count_q <= wb_count_q + 32'd1;
  end

  // Read port A with same-cycle write-through bypass
  always_comb begin
    rs_data = regs[bus.i_rs_addr];
    if (bus.i_rs_addr == 5'd0) rs_data = 32'd0;
    else if (wb_en && (bus.i_rs_addr == bus.i_write_register)) rs_data = wb_data;
  end

  // Read port B with same-cycle write-through bypass
  always_comb begin
    rt_data = regs[bus.i_rt_addr];
    if (bus.i_rt_addr == 5'd0) rt_data = 32'd0;
    else if (wb_en && (bus.i_rt_addr == bus.i_write_register)) rt_data = wb_data;
  end

  // Debug port shows stored contents only, never the pending write
  always_comb begin
    debug_data = regs[bus.i_debug_addr];
    if (bus.i_debug_addr == 5'd0) debug_data = 32'd0;
  end

  assign bus.o_wb_data    = wb_data;
  assign bus.o_wb_en      = wb_en;
  assign bus.o_wb_count   = wb_count_q;
  assign bus.o_rs_data    = rs_data;
  assign bus.o_rt_data    = rt_data;
  assign bus.o_debug_data = debug_data;

endmodule

// File: tb/tb_wb_register_file.sv
// tb/tb_wb_register_file.sv - self-checking bench for wb_register_file
module tb_wb_register_file;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   checks = 0;
  int   errors = 0;

  wb_register_file_if bus ();

  wb_register_file dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rw;
    logic [1:0]  mtr;
    logic [4:0]  wr;
    logic [31:0] res;
    logic [31:0] mrd;
    logic [31:0] pc4;
    logic [31:0] imm;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  dbg;
    logic [31:0] e_wb;
    logic        e_en;
    logic [31:0] e_rs;
    logic [31:0] e_rt;
    logic [31:0] e_dbg_pre;
    logic [31:0] e_dbg_post;
    logic [31:0] e_cnt;
  } vec_t;

  vec_t vecs [7];

  logic [31:0] mregs [32];
  logic [31:0] mcount;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic rw, input logic [1:0] mtr, input logic [4:0] wr,
                       input logic [31:0] res, input logic [31:0] mrd,
                       input logic [31:0] pc4, input logic [31:0] imm,
                       input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] dbg);
    bus.i_reg_write      = rw;
    bus.i_mem_to_reg     = mtr;
    bus.i_write_register = wr;
    bus.i_result         = res;
    bus.i_mem_read_data  = mrd;
    bus.i_pc_4           = pc4;
    bus.i_imm_ext_out    = imm;
    bus.i_rs_addr        = rs;
    bus.i_rt_addr        = rt;
    bus.i_debug_addr     = dbg;
  endtask

  function automatic logic [31:0] ref_mux(input logic [1:0] sel, input logic [31:0] a,
                                          input logic [31:0] b, input logic [31:0] c,
                                          input logic [31:0] d);
    logic [31:0] src [4];
    src[0] = a; src[1] = b; src[2] = c; src[3] = d;
    return src[sel];
  endfunction

  function automatic logic [31:0] ref_read(input logic [4:0] idx, input logic en,
                                           input logic [4:0] wr, input logic [31:0] wbd);
    if (idx == 0) return 32'd0;
    if (en && idx == wr) return wbd;
    return mregs[idx];
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 32; i++) mregs[i] = 32'd0;
    mregs[28] = 32'h0000_1800;
    mregs[29] = 32'h0000_07fc;
    mcount = 32'd0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{1'b1, 2'b00, 5'd5, 32'hdead_beef, 32'd0, 32'd0, 32'd0, 5'd5, 5'd0, 5'd5,
                32'hdead_beef, 1'b1, 32'hdead_beef, 32'd0, 32'd0, 32'hdead_beef, 32'd1};
    vecs[1] = '{1'b1, 2'b01, 5'd8, 32'd1, 32'd2, 32'd3, 32'd4, 5'd8, 5'd5, 5'd8,
                32'd2, 1'b1, 32'd2, 32'hdead_beef, 32'd0, 32'd2, 32'd2};
    vecs[2] = '{1'b1, 2'b10, 5'd8, 32'd1, 32'd2, 32'd3, 32'd4, 5'd8, 5'd5, 5'd8,
                32'd3, 1'b1, 32'd3, 32'hdead_beef, 32'd2, 32'd3, 32'd3};
    vecs[3] = '{1'b1, 2'b11, 5'd8, 32'd1, 32'd2, 32'd3, 32'd4, 5'd8, 5'd8, 5'd8,
                32'd4, 1'b1, 32'd4, 32'd4, 32'd3, 32'd4, 32'd4};
    vecs[4] = '{1'b1, 2'b00, 5'd0, 32'h1234, 32'd0, 32'd0, 32'd0, 5'd0, 5'd0, 5'd0,
                32'h1234, 1'b0, 32'd0, 32'd0, 32'd0, 32'd0, 32'd4};
    vecs[5] = '{1'b0, 2'b00, 5'd5, 32'h55, 32'd0, 32'd0, 32'd0, 5'd5, 5'd8, 5'd5,
                32'h55, 1'b0, 32'hdead_beef, 32'd4, 32'hdead_beef, 32'hdead_beef, 32'd4};
    vecs[6] = '{1'b0, 2'b00, 5'd0, 32'd0, 32'd0, 32'd0, 32'd0, 5'd28, 5'd29, 5'd28,
                32'd0, 1'b0, 32'h1800, 32'h7fc, 32'h1800, 32'h1800, 32'd4};

    // Reset contents
    drive(1'b0, 2'b00, 5'd0, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0);
    repeat (2) @(posedge clk);
    #1;
    model_reset();
    for (int i = 0; i < 32; i++) begin
      bus.i_debug_addr = i[4:0];
      #1;
      chk("reset_debug", bus.o_debug_data, mregs[i]);
    end
    chk("reset_count", bus.o_wb_count, 32'd0);
    drive(1'b1, 2'b10, 5'd3, 32'h11, 32'h22, 32'h44, 32'h88, 5'd3, 5'd29, 5'd3);
    #1;
    chk("reset_wb_en", {31'd0, bus.o_wb_en}, 32'd0);
    chk("reset_wb_data", bus.o_wb_data, 32'h44);
    chk("reset_rs_nobypass", bus.o_rs_data, 32'd0);
    chk("reset_rt_sp", bus.o_rt_data, 32'h7fc);

    // Release reset mid-cycle with no write pending
    @(negedge clk);
    drive(1'b0, 2'b00, 5'd0, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0);
    #2 reset = 1'b1;
    @(posedge clk); #1;
    chk("post_release_count", bus.o_wb_count, 32'd0);

    // Table vectors
    for (int v = 0; v < 7; v++) begin
      @(negedge clk);
      drive(vecs[v].rw, vecs[v].mtr, vecs[v].wr, vecs[v].res, vecs[v].mrd,
            vecs[v].pc4, vecs[v].imm, vecs[v].rs, vecs[v].rt, vecs[v].dbg);
      #1;
      chk("tbl_wb_data", bus.o_wb_data, vecs[v].e_wb);
      chk("tbl_wb_en", {31'd0, bus.o_wb_en}, {31'd0, vecs[v].e_en});
      chk("tbl_rs", bus.o_rs_data, vecs[v].e_rs);
      chk("tbl_rt", bus.o_rt_data, vecs[v].e_rt);
      chk("tbl_dbg_pre", bus.o_debug_data, vecs[v].e_dbg_pre);
      @(posedge clk); #1;
      chk("tbl_dbg_post", bus.o_debug_data, vecs[v].e_dbg_post);
      chk("tbl_count", bus.o_wb_count, vecs[v].e_cnt);
    end

    // Back-to-back writes to the same index
    @(negedge clk);
    drive(1'b1, 2'b00, 5'd10, 32'haaaa_0001, 0, 0, 0, 5'd10, 5'd10, 5'd10);
    #1;
    chk("b2b_rs_first", bus.o_rs_data, 32'haaaa_0001);
    @(negedge clk);
    drive(1'b1, 2'b01, 5'd10, 0, 32'hbbbb_0002, 0, 0, 5'd10, 5'd10, 5'd10);
    #1;
    chk("b2b_rs_second", bus.o_rs_data, 32'hbbbb_0002);
    chk("b2b_dbg_mid", bus.o_debug_data, 32'haaaa_0001);
    @(posedge clk); #1;
    chk("b2b_dbg_final", bus.o_debug_data, 32'hbbbb_0002);
    chk("b2b_count", bus.o_wb_count, 32'd6);

    // Randomized traffic against the reference model, from a fresh reset
    @(negedge clk);
    drive(1'b0, 2'b00, 5'd0, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0);
    reset = 1'b0;
    #1 reset = 1'b1;
    model_reset();
    for (int n = 0; n < 400; n++) begin
      logic        rw;
      logic [4:0]  wr, rs, rt, dbg;
      logic [1:0]  mtr;
      logic [31:0] a, b, c, d, wbd;
      logic        en;
      @(negedge clk);
      rw  = ($urandom_range(0, 3) != 0);
      wr  = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom_range(0, 31));
      mtr = 2'($urandom_range(0, 3));
      a = $urandom; b = $urandom; c = $urandom; d = $urandom;
      rs  = ($urandom_range(0, 2) == 0) ? wr : 5'($urandom_range(0, 31));
      rt  = ($urandom_range(0, 2) == 0) ? wr : 5'($urandom_range(0, 31));
      dbg = ($urandom_range(0, 2) == 0) ? wr : 5'($urandom_range(0, 31));
      drive(rw, mtr, wr, a, b, c, d, rs, rt, dbg);
      wbd = ref_mux(mtr, a, b, c, d);
      en  = rw && (wr != 0);
      #1;
      chk("rnd_wb_data", bus.o_wb_data, wbd);
      chk("rnd_wb_en", {31'd0, bus.o_wb_en}, {31'd0, en});
      chk("rnd_rs", bus.o_rs_data, ref_read(rs, en, wr, wbd));
      chk("rnd_rt", bus.o_rt_data, ref_read(rt, en, wr, wbd));
      chk("rnd_dbg", bus.o_debug_data, (dbg == 0) ? 32'd0 : mregs[dbg]);
      @(posedge clk);
      if (en) begin
        mregs[wr] = wbd;
        mcount = mcount + 1;
      end
      #1;
      chk("rnd_count", bus.o_wb_count, mcount);
    end

    // Reset asserted between edges while a write to $sp is pending
    @(negedge clk);
    drive(1'b1, 2'b00, 5'd29, 32'hcafe_f00d, 0, 0, 0, 5'd29, 5'd0, 5'd29);
    #1;
    chk("pend_wb_en", {31'd0, bus.o_wb_en}, 32'd1);
    chk("pend_rs_bypass", bus.o_rs_data, 32'hcafe_f00d);
    #2 reset = 1'b0;
    #1;
    chk("rst_mid_dbg29", bus.o_debug_data, 32'h0000_07fc);
    chk("rst_mid_rs29", bus.o_rs_data, 32'h0000_07fc);
    chk("rst_mid_count", bus.o_wb_count, 32'd0);
    chk("rst_mid_wb_en", {31'd0, bus.o_wb_en}, 32'd0);
    chk("rst_mid_wb_data", bus.o_wb_data, 32'hcafe_f00d);
    @(posedge clk); #1;
    chk("rst_edge_dbg29", bus.o_debug_data, 32'h0000_07fc);
    chk("rst_edge_count", bus.o_wb_count, 32'd0);
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    chk("rel_wb_en", {31'd0, bus.o_wb_en}, 32'd1);
    chk("rel_dbg29_pre", bus.o_debug_data, 32'h0000_07fc);
    @(posedge clk); #1;
    chk("rel_dbg29_post", bus.o_debug_data, 32'hcafe_f00d);
    chk("rel_count", bus.o_wb_count, 32'd1);

    // Counter wrap
    @(negedge clk);
    drive(1'b0, 2'b00, 5'd0, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0);
    force dut.wb_count_q = 32'hffff_fffe;
    #1 release dut.wb_count_q;
    #1;
    chk("wrap_preload", bus.o_wb_count, 32'hffff_fffe);
    drive(1'b1, 2'b00, 5'd3, 32'd7, 0, 0, 0, 5'd3, 5'd0, 5'd3);
    @(posedge clk); #1;
    chk("wrap_first", bus.o_wb_count, 32'hffff_ffff);
    @(negedge clk);
    drive(1'b1, 2'b00, 5'd4, 32'd9, 0, 0, 0, 5'd4, 5'd0, 5'd4);
    @(posedge clk); #1;
    chk("wrap_zero", bus.o_wb_count, 32'd0);
    chk("wrap_dbg4", bus.o_debug_data, 32'd9);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
